// File: rtl/wb_retire_buffer.sv
// wb_retire_buffer
// Multi-lane writeback retire buffer. Each cycle it takes up to LANES completed
// results from MEM and stores them in an in-order FIFO. It retires one entry per
// cycle into an output register. That register drives the GPR write port, the
// HI/LO write bus and the debug trace, so the trace shows one retirement per
// cycle. A combinational lookup forwards the youngest pending GPR write.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_pc/...    per-lane results; lane i is at [i*W +: W], lane 0 oldest
//   in_ready, stallreq    room for a full LANES group / its inverse
//   count                 current FIFO occupancy
//   rf_we/rf_waddr/...    registered GPR write port
//   hilo_we/hi_o/lo_o     registered HI/LO write bus
//   fwd_raddr/fwd_hit/... forwarding lookup over buffered and retiring results
//   debug_wb_*            retirement trace
module wb_retire_buffer #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*PC_W-1:0]        in_pc,
  input  logic [LANES-1:0]             in_we,
  input  logic [LANES*5-1:0]           in_waddr,
  input  logic [LANES*DATA_W-1:0]      in_wdata,
  input  logic [LANES-1:0]             in_hilo_we,
  input  logic [LANES*DATA_W-1:0]      in_hi,
  input  logic [LANES*DATA_W-1:0]      in_lo,
  output logic                         in_ready,
  output logic                         stallreq,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic                         hilo_we,
  output logic [DATA_W-1:0]            hi_o,
  output logic [DATA_W-1:0]            lo_o,
  input  logic [4:0]                   fwd_raddr,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data,
  output logic [PC_W-1:0]              debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_wen,
  output logic [4:0]                   debug_wb_rf_wnum,
  output logic [DATA_W-1:0]            debug_wb_rf_wdata
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [PC_W-1:0]   mem_pc      [DEPTH];
  logic              mem_we      [DEPTH];
  logic [4:0]        mem_waddr   [DEPTH];
  logic [DATA_W-1:0] mem_wdata   [DEPTH];
  logic              mem_hilo_we [DEPTH];
  logic [DATA_W-1:0] mem_hi      [DEPTH];
  logic [DATA_W-1:0] mem_lo      [DEPTH];

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] push_cnt;
  logic [PW-1:0] lane_slot [LANES];
  logic          pop;

  // The ready decision uses only registered occupancy. A pop in the same
  // cycle does not free space early, so there is no combinational path from
  // the pop side to the stall controller.
  assign in_ready = (int'(count) + LANES) <= DEPTH;
  assign stallreq = ~in_ready;
  assign pop      = (count != '0);

  // Compaction: each valid lane takes the slot after all lower valid lanes.
  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_slot[i] = tail_ptr + acc[PW-1:0];
      if (in_valid[i]) acc = acc + CW'(1);
    end
    push_cnt = in_ready ? acc : '0;
  end

  // Entry storage needs no reset, because occupancy alone decides which slots
  // are live.
  always_ff @(posedge clk) begin
    if (in_ready && !rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i]) begin
          mem_pc[lane_slot[i]]      <= in_pc[i*PC_W +: PC_W];
          mem_we[lane_slot[i]]      <= in_we[i];
          mem_waddr[lane_slot[i]]   <= in_waddr[i*5 +: 5];
          mem_wdata[lane_slot[i]]   <= in_wdata[i*DATA_W +: DATA_W];
          mem_hilo_we[lane_slot[i]] <= in_hilo_we[i];
          mem_hi[lane_slot[i]]      <= in_hi[i*DATA_W +: DATA_W];
          mem_lo[lane_slot[i]]      <= in_lo[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Pointers and occupancy. A push of k entries and a pop of one in the same
  // cycle give count + k - 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (pop) head_ptr <= head_ptr + PW'(1);
      tail_ptr <= tail_ptr + push_cnt[PW-1:0];
      count    <= count + push_cnt - CW'(pop);
    end
  end

  // Retirement register. It loads zeros when the FIFO is empty, so an idle
  // cycle shows no write and a zero PC on the trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      hilo_we     <= 1'b0;
      hi_o        <= '0;
      lo_o        <= '0;
      debug_wb_pc <= '0;
    end else if (pop) begin
      rf_we       <= mem_we[head_ptr];
      rf_waddr    <= mem_waddr[head_ptr];
      rf_wdata    <= mem_wdata[head_ptr];
      hilo_we     <= mem_hilo_we[head_ptr];
      hi_o        <= mem_hi[head_ptr];
      lo_o        <= mem_lo[head_ptr];
      debug_wb_pc <= mem_pc[head_ptr];
    end else begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      hilo_we     <= 1'b0;
      hi_o        <= '0;
      lo_o        <= '0;
      debug_wb_pc <= '0;
    end
  end

  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Forwarding search. The retiring register is the oldest pending write, so
  // it is checked first. The FIFO is then scanned oldest to youngest, and each
  // later match overrides the previous one, which leaves the youngest writer.
  always_comb begin
    logic [PW-1:0] fidx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fidx     = '0;
    if (fwd_raddr != 5'd0) begin
      if (rf_we && (rf_waddr == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_wdata;
      end
      for (int j = 0; j < DEPTH; j++) begin
        fidx = head_ptr + PW'(j);
        if ((j < int'(count)) && mem_we[fidx] && (mem_waddr[fidx] == fwd_raddr)) begin
          fwd_hit  = 1'b1;
          fwd_data = mem_wdata[fidx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_retire_buffer.sv
// tb_wb_retire_buffer
// Scoreboard bench for wb_retire_buffer with LANES=2 and DEPTH=8. Each accepted
// lane is pushed to a queue of expected entries. At every clock edge the model
// pops the oldest entry into an expected retirement register, using the same
// ready rule as the buffer. All outputs, including the forwarding lookup, are
// then compared on the falling edge.
module tb_wb_retire_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } entry_t;

  logic        clk;
  logic        rst;
  logic [1:0]  lane_v;
  entry_t      lane_e [2];
  logic [4:0]  fwd_raddr;

  logic        in_ready, stallreq, rf_we, hilo_we, fwd_hit;
  logic [3:0]  count, debug_wb_rf_wen;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, hi_o, lo_o, fwd_data, debug_wb_pc, debug_wb_rf_wdata;

  entry_t sb[$];
  entry_t exp_out;
  int     checks;
  int     failures;

  wb_retire_buffer #(.LANES(2), .DEPTH(8), .DATA_W(32), .PC_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (lane_v),
    .in_pc             ({lane_e[1].pc, lane_e[0].pc}),
    .in_we             ({lane_e[1].we, lane_e[0].we}),
    .in_waddr          ({lane_e[1].waddr, lane_e[0].waddr}),
    .in_wdata          ({lane_e[1].wdata, lane_e[0].wdata}),
    .in_hilo_we        ({lane_e[1].hilo_we, lane_e[0].hilo_we}),
    .in_hi             ({lane_e[1].hi, lane_e[0].hi}),
    .in_lo             ({lane_e[1].lo, lane_e[0].lo}),
    .in_ready          (in_ready),
    .stallreq          (stallreq),
    .count             (count),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .hilo_we           (hilo_we),
    .hi_o              (hi_o),
    .lo_o              (lo_o),
    .fwd_raddr         (fwd_raddr),
    .fwd_hit           (fwd_hit),
    .fwd_data          (fwd_data),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] pc, input logic we, input logic [4:0] waddr,
                                input logic [31:0] wdata, input logic hilo_we,
                                input logic [31:0] hi, input logic [31:0] lo);
    entry_t e;
    e.pc = pc; e.we = we; e.waddr = waddr; e.wdata = wdata;
    e.hilo_we = hilo_we; e.hi = hi; e.lo = lo;
    return e;
  endfunction

  task automatic applyStimulus(input logic [1:0] v, input entry_t e0, input entry_t e1);
    lane_v    = v;
    lane_e[0] = e0;
    lane_e[1] = e1;
  endtask

  // Compares every output against the model's occupancy, its expected
  // retirement register and a forwarding search over the model queue.
  task automatic compareAll();
    logic        ehit;
    logic [31:0] edata;
    int          occ;
    occ   = sb.size();
    ehit  = 1'b0;
    edata = '0;
    if (fwd_raddr != 5'd0) begin
      if (exp_out.we && exp_out.waddr == fwd_raddr) begin ehit = 1'b1; edata = exp_out.wdata; end
      for (int k = 0; k < sb.size(); k++)
        if (sb[k].we && sb[k].waddr == fwd_raddr) begin ehit = 1'b1; edata = sb[k].wdata; end
    end
    checkOutput("count",     64'(count),             64'(occ));
    checkOutput("in_ready",  64'(in_ready),          64'((occ + 2) <= 8));
    checkOutput("stallreq",  64'(stallreq),          64'((occ + 2) > 8));
    checkOutput("rf_we",     64'(rf_we),             64'(exp_out.we));
    checkOutput("rf_waddr",  64'(rf_waddr),          64'(exp_out.waddr));
    checkOutput("rf_wdata",  64'(rf_wdata),          64'(exp_out.wdata));
    checkOutput("hilo_we",   64'(hilo_we),           64'(exp_out.hilo_we));
    checkOutput("hi_o",      64'(hi_o),              64'(exp_out.hi));
    checkOutput("lo_o",      64'(lo_o),              64'(exp_out.lo));
    checkOutput("wb_pc",     64'(debug_wb_pc),       64'(exp_out.pc));
    checkOutput("wb_wen",    64'(debug_wb_rf_wen),   64'(exp_out.we ? 4'hF : 4'h0));
    checkOutput("wb_wnum",   64'(debug_wb_rf_wnum),  64'(exp_out.waddr));
    checkOutput("wb_wdata",  64'(debug_wb_rf_wdata), 64'(exp_out.wdata));
    checkOutput("fwd_hit",   64'(fwd_hit),           64'(ehit));
    checkOutput("fwd_data",  64'(fwd_data),          64'(edata));
  endtask

  // One clock: the model advances at the rising edge (the ready decision
  // uses occupancy before the pop, and the pop happens before the push),
  // and the outputs are compared at the falling edge.
  task automatic stepCycle();
    bit ready;
    @(posedge clk);
    ready = (sb.size() + 2) <= 8;
    if (sb.size() > 0) exp_out = sb.pop_front();
    else               exp_out = '0;
    if (ready) begin
      if (lane_v[0]) sb.push_back(lane_e[0]);
      if (lane_v[1]) sb.push_back(lane_e[1]);
    end
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(2'b00, '0, '0);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  initial begin
    int     n;
    int     guard;
    bit     accept;
    entry_t r0;
    entry_t r1;
    checks    = 0;
    failures  = 0;
    exp_out   = '0;
    fwd_raddr = 5'd0;
    rst       = 1'b1;
    applyStimulus(2'b00, '0, '0);
    repeat (2) @(negedge clk);
    compareAll();
    rst = 1'b0;
    idleCycles(10);

    // Paired results retire one per cycle in PC order.
    applyStimulus(2'b11, mk(32'hBFC00000, 1'b1, 5'd3, 32'h11, 1'b0, 0, 0),
                         mk(32'hBFC00004, 1'b1, 5'd4, 32'h22, 1'b0, 0, 0));
    stepCycle();
    idleCycles(3);

    // Only lane 1 is valid: a single compacted entry.
    applyStimulus(2'b10, '0, mk(32'hBFC00008, 1'b1, 5'd5, 32'h55, 1'b0, 0, 0));
    stepCycle();
    idleCycles(2);

    // Forwarding: the youngest r7 wins, within one group and across cycles.
    fwd_raddr = 5'd7;
    applyStimulus(2'b11, mk(32'hBFC00010, 1'b1, 5'd7, 32'h1, 1'b0, 0, 0),
                         mk(32'hBFC00014, 1'b1, 5'd7, 32'h2, 1'b0, 0, 0));
    stepCycle();
    idleCycles(3);
    applyStimulus(2'b01, mk(32'hBFC00018, 1'b1, 5'd7, 32'h1, 1'b0, 0, 0), '0);
    stepCycle();
    applyStimulus(2'b01, mk(32'hBFC0001C, 1'b1, 5'd7, 32'h2, 1'b0, 0, 0), '0);
    stepCycle();
    idleCycles(3);
    fwd_raddr = 5'd0;
    applyStimulus(2'b01, mk(32'hBFC00020, 1'b1, 5'd0, 32'h99, 1'b0, 0, 0), '0);
    stepCycle();
    idleCycles(2);

    // A store-like entry that writes only HI/LO still takes a trace slot.
    applyStimulus(2'b01, mk(32'hBFC00100, 1'b0, 5'd9, 32'h77, 1'b1, 32'hA, 32'hB), '0);
    stepCycle();
    idleCycles(2);

    // Continuous streaming of 64 results. A group is held until it is accepted.
    fwd_raddr = 5'd6;
    n = 0;
    guard = 0;
    while (n < 64 && guard < 300) begin
      r0 = mk(32'hBFC01000 + 32'(n * 4),       1'b1, 5'(n % 8 + 1),       32'(n * 3 + 1), 1'(n % 3 == 0), 32'(n), 32'(n + 100));
      r1 = mk(32'hBFC01000 + 32'((n + 1) * 4), 1'b1, 5'((n + 1) % 8 + 1), 32'(n * 3 + 2), 1'b0,           0,      0);
      applyStimulus(2'b11, r0, r1);
      accept = (sb.size() + 2) <= 8;
      stepCycle();
      if (accept) n += 2;
      guard++;
    end
    idleCycles(10);

    // Random valid patterns with low register numbers so forwarding sees hits.
    for (int c = 0; c < 40; c++) begin
      fwd_raddr = 5'($urandom_range(0, 7));
      applyStimulus(2'($urandom_range(0, 3)),
                    mk(32'hBFC02000 + 32'(c * 8), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom),
                    mk(32'hBFC02004 + 32'(c * 8), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom));
      stepCycle();
    end
    idleCycles(10);

    // Reset in the middle of a burst throws away everything buffered.
    fwd_raddr = 5'd2;
    applyStimulus(2'b11, mk(32'hBFC03000, 1'b1, 5'd1, 32'hA1, 1'b0, 0, 0),
                         mk(32'hBFC03004, 1'b1, 5'd2, 32'hA2, 1'b0, 0, 0));
    stepCycle();
    applyStimulus(2'b11, mk(32'hBFC03008, 1'b1, 5'd2, 32'hA3, 1'b0, 0, 0),
                         mk(32'hBFC0300C, 1'b1, 5'd4, 32'hA4, 1'b0, 0, 0));
    stepCycle();
    applyStimulus(2'b01, mk(32'hBFC03010, 1'b1, 5'd2, 32'hA5, 1'b1, 1, 2), '0);
    stepCycle();
    applyStimulus(2'b00, '0, '0);
    #2 rst = 1'b1;
    sb.delete();
    exp_out = '0;
    #1 compareAll();
    @(negedge clk);
    rst = 1'b0;
    idleCycles(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_retire_buffer.md
Name: wb_retire_buffer

Overview:
- Parametrised successor to the single-lane writeback stage for the multi-issue CPU.
- Each cycle, accepts up to LANES completed results from MEM into an in-order retire FIFO.
- Drains one entry per cycle to the register-file write port, the HI/LO write bus and the debug trace port, so the trace stays one retirement per cycle.
- Provides a forwarding lookup over all buffered, not-yet-written results.

Parameters:
- LANES, 2, result lanes presented per cycle; lane 0 is the oldest.
- DEPTH, 8, FIFO entries; must be ≥ LANES; power of two.
- DATA_W, 32, width of GPR and HI/LO data.
- PC_W, 32, width of the PC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  LANES  per-lane result valid.
- in_pc  in  LANES*PC_W  per-lane PC; lane i occupies bits [i*PC_W +: PC_W].
- in_we  in  LANES  per-lane GPR write enable.
- in_waddr  in  LANES*5  per-lane GPR address.
- in_wdata  in  LANES*DATA_W  per-lane GPR data.
- in_hilo_we  in  LANES  per-lane HI/LO write enable.
- in_hi  in  LANES*DATA_W  per-lane HI value.
- in_lo  in  LANES*DATA_W  per-lane LO value.
- in_ready  out  1  FIFO can take a full LANES group this cycle.
- stallreq  out  1  equals ~in_ready; goes to the stall controller.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- rf_we  out  1  GPR write enable.
- rf_waddr  out  5  GPR write address.
- rf_wdata  out  DATA_W  GPR write data.
- hilo_we  out  1  HI/LO write enable.
- hi_o  out  DATA_W  HI write data.
- lo_o  out  DATA_W  LO write data.
- fwd_raddr  in  5  forwarding lookup address.
- fwd_hit  out  1  a pending write to fwd_raddr exists.
- fwd_data  out  DATA_W  data of the youngest pending write to fwd_raddr.
- debug_wb_pc  out  PC_W  PC of the retiring entry.
- debug_wb_rf_wen  out  4  {4{rf_we}}.
- debug_wb_rf_wnum  out  5  equals rf_waddr.
- debug_wb_rf_wdata  out  DATA_W  equals rf_wdata.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is asynchronous and active-high.
  - While rst=1: FIFO empty, head and tail pointers 0, count=0, output register cleared (rf_we=0, hilo_we=0, all data, address and PC outputs 0).
  - rst asserted mid-operation discards all buffered entries; nothing is written after rst deasserts.
- Enqueue:
  - in_ready = (DEPTH − count) ≥ LANES, computed from registered count only; a same-cycle pop is not credited.
  - When in_ready=1, every lane with in_valid=1 is written at the rising edge.
  - Valid lanes are compacted in ascending lane order into consecutive slots; invalid lanes consume no slot.
  - When in_ready=0, inputs are ignored. Upstream holds them, stalled via stallreq.
- Dequeue:
  - When count>0, the head entry is moved into the output register at each edge and the head pointer advances.
  - When count=0, the output register loads zeros: no write, debug_wb_pc=0, wen=0.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push of k entries and pop of 1 gives count_next = count + k − 1.
- Latency: a result captured at edge N reaches the rf_*/debug outputs after edge N+1 when the FIFO was empty, and is written to the regfile at edge N+2.
- Non-writing entries: an entry with we=0 (e.g. a store) still retires and occupies one trace cycle, with debug_wb_pc=its PC and debug_wb_rf_wen=0. hilo_we is independent of rf_we.
- Forwarding lookup (combinational):
  - Searches all valid FIFO entries youngest-first, then the output register.
  - Only entries with we=1 and waddr==fwd_raddr qualify.
  - The youngest match supplies fwd_data.
  - fwd_raddr=0 never hits.
  - When there is no hit, fwd_hit=0 and fwd_data=0.
  - Same-cycle input lanes are not searched; MEM-stage forwarding covers them.
- HI/LO values retire in order through the same FIFO, so the last writer wins naturally.

Test Plan:
- Reset then idle → count=0, in_ready=1, rf_we=0, debug_wb_pc=0 for 10 cycles; assert rst mid-burst with 5 entries → outputs zero immediately, no later writes.
- Lane0 {pc=0xBFC00000, we=1, r3, 0x11}, lane1 {pc=0xBFC00004, we=1, r4, 0x22} in one cycle → trace shows r3=0x11 on cycle N+1 and r4=0x22 on cycle N+2, in PC order.
- Lane0 invalid, lane1 valid {r5, 0x55} → single entry, count=1, retires next cycle.
- Push 2 per cycle continuously, DEPTH=8 → count saturates; in_ready=0 exactly when count ≥ 7; no entry lost or duplicated over 64 results; pointers wrap correctly.
- Buffered r7=0x1, then r7=0x2, fwd_raddr=7 → fwd_hit=1, fwd_data=0x2; fwd_raddr=0 with a pending r0 write → fwd_hit=0.
- Lane0 {we=0, hilo_we=1, hi=0xA, lo=0xB} → rf_we=0, hilo_we=1, hi_o=0xA, lo_o=0xB, debug_wb_rf_wen=0, debug_wb_pc=lane PC.
